tile_bank_cfg_ctrl: RTL and testbench



---
 rtl/tile_cfg_pkg.sv | 22 ++
 rtl/tile_bank_cfg_ctrl_timer.sv | 35 +++
 rtl/tile_bank_cfg_ctrl.sv | 129 ++++++++++++
 tb/tb_tile_bank_cfg_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_cfg_pkg.sv
// Shared types and helpers for the tile bank configuration controller.
// Holds the FSM state encoding, default geometry and chunk addressing.
package tile_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_REJECT
    } state_e;

    localparam int NUM_BITS_DEF = 160;
    localparam int CHUNK_W_DEF  = 8;
    localparam int NUM_CHUNKS   = NUM_BITS_DEF / CHUNK_W_DEF;
    localparam int IDX_W        = $clog2(NUM_CHUNKS);

    function automatic int chunk_base(input int idx, input int chunk_w);
        return idx * chunk_w;
    endfunction

endpackage

// File: rtl/tile_bank_cfg_ctrl_timer.sv
// Phase down-counter: load a cycle count, expire flags the last cycle.
// Idles at zero once a phase has run out.
module cfg_phase_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == W'(1));

endmodule

// File: rtl/tile_bank_cfg_ctrl.sv
// Memory-bank config controller: one chunk write per command,
// driving bl, then pulsing wl with fixed setup/pulse/hold timing.
module tile_bank_cfg_ctrl
    import tile_cfg_pkg::*;
#(
    parameter  int NUM_BITS     = NUM_BITS_DEF,
    parameter  int CHUNK_W      = CHUNK_W_DEF,
    parameter  int SETUP_CYCLES = 1,
    parameter  int PULSE_CYCLES = 2,
    parameter  int CNT_W        = 16,
    localparam int N_CHUNKS     = NUM_BITS / CHUNK_W,
    localparam int CIDX_W       = $clog2(N_CHUNKS)
) (
    input  logic                prog_clk,
    input  logic                prog_reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [CIDX_W-1:0]   cmd_chunk,
    input  logic [CHUNK_W-1:0]  cmd_data,
    output logic                busy,
    output logic                done_pulse,
    output logic                err_pulse,
    output logic [CNT_W-1:0]    write_count,
    output logic [0:NUM_BITS-1] bl,
    output logic [0:NUM_BITS-1] wl
);

    localparam int MAX_CYC = (SETUP_CYCLES > PULSE_CYCLES) ?
                             SETUP_CYCLES : PULSE_CYCLES;
    localparam int TMR_W   = $clog2(MAX_CYC + 1);

    state_e             state_q, state_d;
    logic [CIDX_W-1:0]  chunk_q, chunk_d;
    logic [CHUNK_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               tmr_load;
    logic [TMR_W-1:0]   tmr_val;
    logic               tmr_expire;
    logic               drive_bl;
    logic               strobe_wl;
    logic [N_CHUNKS-1:0] sel;

    cfg_phase_timer #(
        .W(TMR_W)
    ) u_timer (
        .clk     (prog_clk),
        .rst     (prog_reset),
        .load    (tmr_load),
        .load_val(tmr_val),
        .expire  (tmr_expire)
    );

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state_q <= ST_IDLE;
            chunk_q <= '0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            chunk_q <= chunk_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        chunk_d  = chunk_q;
        data_d   = data_q;
        count_d  = count_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (32'(cmd_chunk) < N_CHUNKS) begin
                        state_d  = ST_SETUP;
                        chunk_d  = cmd_chunk;
                        data_d   = cmd_data;
                        tmr_load = 1'b1;
                        tmr_val  = TMR_W'(SETUP_CYCLES);
                    end else begin
                        state_d = ST_REJECT;
                    end
                end
            end
            ST_SETUP: begin
                if (tmr_expire) begin
                    state_d  = ST_PULSE;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(PULSE_CYCLES);
                end
            end
            ST_PULSE: begin
                if (tmr_expire) begin
                    state_d = ST_HOLD;
                    count_d = count_q + CNT_W'(1);
                end
            end
            ST_HOLD:   state_d = ST_IDLE;
            ST_REJECT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready  = (state_q == ST_IDLE);
        busy       = (state_q != ST_IDLE);
        done_pulse = (state_q == ST_HOLD);
        err_pulse  = (state_q == ST_REJECT);
        drive_bl   = (state_q == ST_SETUP) || (state_q == ST_PULSE) ||
                     (state_q == ST_HOLD);
        strobe_wl  = (state_q == ST_PULSE);
    end

    assign write_count = count_q;

    // Bit i of the latched data lands on cell base+i (ascending bus).
    for (genvar c = 0; c < N_CHUNKS; c++) begin : g_chunk
        assign sel[c] = (chunk_q == CIDX_W'(c));
        for (genvar i = 0; i < CHUNK_W; i++) begin : g_bit
            assign bl[chunk_base(c, CHUNK_W) + i] = drive_bl & sel[c] & data_q[i];
            assign wl[chunk_base(c, CHUNK_W) + i] = strobe_wl & sel[c];
        end
    end

endmodule

// File: tb/tb_tile_bank_cfg_ctrl.sv
// Self-checking bench for tile_bank_cfg_ctrl against a cycle-offset model.
// A narrow-counter second instance shares the stimulus to exercise wrap.
module tb_tile_bank_cfg_ctrl;

    localparam int NB    = 160;
    localparam int CW    = 8;
    localparam int NCH   = NB / CW;
    localparam int S     = 1;
    localparam int P     = 2;
    localparam int T_HLD = S + P + 1;
    localparam int T_RDY = S + P + 2;

    logic          prog_clk;
    logic          prog_reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [4:0]    cmd_chunk;
    logic [CW-1:0] cmd_data;
    logic          busy;
    logic          done_pulse;
    logic          err_pulse;
    logic [15:0]   write_count;
    logic [0:NB-1] bl;
    logic [0:NB-1] wl;

    logic          w_ready, w_busy, w_done, w_err;
    logic [2:0]    w_count;
    logic [0:NB-1] w_bl, w_wl;

    int            n_cmp;
    int            n_bad;
    logic [15:0]   model_count;
    logic          rst_edge;
    logic [0:NB-1] prev_bl, prev_wl;

    tile_bank_cfg_ctrl dut (
        .prog_clk   (prog_clk),
        .prog_reset (prog_reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_chunk  (cmd_chunk),
        .cmd_data   (cmd_data),
        .busy       (busy),
        .done_pulse (done_pulse),
        .err_pulse  (err_pulse),
        .write_count(write_count),
        .bl         (bl),
        .wl         (wl)
    );

    tile_bank_cfg_ctrl #(.CNT_W(3)) dut_w (
        .prog_clk   (prog_clk),
        .prog_reset (prog_reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (w_ready),
        .cmd_chunk  (cmd_chunk),
        .cmd_data   (cmd_data),
        .busy       (w_busy),
        .done_pulse (w_done),
        .err_pulse  (w_err),
        .write_count(w_count),
        .bl         (w_bl),
        .wl         (w_wl)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    function automatic logic [0:NB-1] place(input int ch, input logic [CW-1:0] d);
        logic [0:NB-1] v;
        v = '0;
        for (int i = 0; i < CW; i++) v[ch * CW + i] = d[i];
        return v;
    endfunction

    function automatic logic [0:NB-1] mask(input int ch);
        logic [0:NB-1] v;
        v = '0;
        for (int i = 0; i < CW; i++) v[ch * CW + i] = 1'b1;
        return v;
    endfunction

    // Bus invariants: no same-cycle bl/wl change, one wl chunk at most.
    initial rst_edge = 1'b1;
    always @(posedge prog_clk) rst_edge <= prog_reset;

    always @(negedge prog_clk) begin
        int hot;
        if (!rst_edge) begin
            n_cmp++;
            if (bl !== prev_bl && wl !== prev_wl) begin
                n_bad++;
                $display("FAIL bl_wl_same_cycle: bl %h->%h wl %h->%h",
                         prev_bl, bl, prev_wl, wl);
            end
            hot = 0;
            for (int c = 0; c < NCH; c++) begin
                logic any;
                any = 1'b0;
                for (int i = 0; i < CW; i++) any |= wl[c * CW + i];
                if (any) hot++;
            end
            n_cmp++;
            if (hot > 1) begin
                n_bad++;
                $display("FAIL wl_one_chunk: got %0d chunks want <=1", hot);
            end
        end
        prev_bl = bl;
        prev_wl = wl;
    end

    task automatic check_idle(input string tag);
        n_cmp++;
        if ({cmd_ready, busy, done_pulse, err_pulse} !== 4'b1000) begin
            n_bad++;
            $display("FAIL %s_flags: got rdy/busy/done/err=%b want 1000", tag,
                     {cmd_ready, busy, done_pulse, err_pulse});
        end
        n_cmp++;
        if ({bl, wl} !== '0) begin
            n_bad++;
            $display("FAIL %s_bus: got bl=%h wl=%h want 0", tag, bl, wl);
        end
        n_cmp++;
        if (write_count !== model_count || w_count !== model_count[2:0]) begin
            n_bad++;
            $display("FAIL %s_count: got %h/%h want %h/%h", tag, write_count,
                     w_count, model_count, model_count[2:0]);
        end
    endtask

    task automatic test_reset();
        prog_reset = 1'b1;
        cmd_valid  = 1'b0;
        cmd_chunk  = '0;
        cmd_data   = '0;
        model_count = '0;
        repeat (3) @(negedge prog_clk);
        check_idle("reset_held");
        prog_reset = 1'b0;
        @(negedge prog_clk);
        check_idle("reset_released");
    endtask

    task automatic run_write(input int ch, input logic [CW-1:0] d);
        logic [0:NB-1] ebl, ewl;
        logic [3:0]    eflags;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL write_ready_pre: got %b want 1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_chunk = 5'(ch);
        cmd_data  = d;
        @(negedge prog_clk);
        cmd_valid = 1'b0;
        cmd_chunk = 5'($urandom);
        cmd_data  = 8'($urandom);
        for (int t = 1; t <= T_RDY; t++) begin
            if (t > 1) @(negedge prog_clk);
            if (t == T_HLD) model_count++;
            ebl = (t <= T_HLD) ? place(ch, d) : '0;
            ewl = (t >= S + 1 && t <= S + P) ? mask(ch) : '0;
            eflags = {t == T_RDY, t != T_RDY, t == T_HLD, 1'b0};
            n_cmp++;
            if (bl !== ebl || wl !== ewl) begin
                n_bad++;
                $display("FAIL write_bus ch%0d t%0d: got bl=%h wl=%h want bl=%h wl=%h",
                         ch, t, bl, wl, ebl, ewl);
            end
            n_cmp++;
            if ({cmd_ready, busy, done_pulse, err_pulse} !== eflags) begin
                n_bad++;
                $display("FAIL write_flags ch%0d t%0d: got %b want %b", ch, t,
                         {cmd_ready, busy, done_pulse, err_pulse}, eflags);
            end
            n_cmp++;
            if (write_count !== model_count || w_count !== model_count[2:0]) begin
                n_bad++;
                $display("FAIL write_count t%0d: got %h/%h want %h/%h", t,
                         write_count, w_count, model_count, model_count[2:0]);
            end
        end
    endtask

    task automatic run_reject(input int ch);
        cmd_valid = 1'b1;
        cmd_chunk = 5'(ch);
        cmd_data  = 8'($urandom);
        @(negedge prog_clk);
        cmd_valid = 1'b0;
        n_cmp++;
        if ({cmd_ready, busy, done_pulse, err_pulse} !== 4'b0101) begin
            n_bad++;
            $display("FAIL reject_flags ch%0d: got %b want 0101", ch,
                     {cmd_ready, busy, done_pulse, err_pulse});
        end
        n_cmp++;
        if ({bl, wl} !== '0 || write_count !== model_count) begin
            n_bad++;
            $display("FAIL reject_bus ch%0d: got bl=%h wl=%h cnt=%h want 0/0/%h",
                     ch, bl, wl, write_count, model_count);
        end
        @(negedge prog_clk);
        check_idle("reject_after");
    endtask

    task automatic test_directed();
        run_write(0, 8'hA5);
        n_cmp++;
        if (write_count !== 16'd1) begin
            n_bad++;
            $display("FAIL directed_count: got %0d want 1", write_count);
        end
    endtask

    task automatic test_last_chunk();
        run_write(NCH - 1, 8'hFF);
    endtask

    task automatic test_reject();
        run_reject(NCH);
        run_reject(31);
    endtask

    task automatic test_back_to_back();
        int n_acc;
        int n_done;
        bit acc_prev;
        logic [15:0] start;
        start = model_count;
        n_acc = 0;
        n_done = 0;
        acc_prev = 1'b0;
        cmd_valid = 1'b1;
        cmd_chunk = 5'($urandom_range(0, NCH - 1));
        cmd_data  = 8'($urandom);
        for (int cyc = 0; cyc < 18; cyc++) begin
            if (acc_prev) begin
                if (n_acc == 3) cmd_valid = 1'b0;
                cmd_chunk = 5'($urandom_range(0, NCH - 1));
                cmd_data  = 8'($urandom);
            end
            n_cmp++;
            if (cmd_ready !== (cyc % 5 == 0 || cyc >= 15)) begin
                n_bad++;
                $display("FAIL b2b_ready cyc%0d: got %b want %b", cyc, cmd_ready,
                         (cyc % 5 == 0 || cyc >= 15));
            end
            n_cmp++;
            if (done_pulse !== (cyc % 5 == 4 && cyc < 15)) begin
                n_bad++;
                $display("FAIL b2b_done cyc%0d: got %b want %b", cyc, done_pulse,
                         (cyc % 5 == 4 && cyc < 15));
            end
            if (done_pulse === 1'b1) n_done++;
            acc_prev = (cmd_ready === 1'b1) && cmd_valid;
            if (acc_prev) n_acc++;
            @(negedge prog_clk);
        end
        cmd_valid = 1'b0;
        model_count = start + 16'd3;
        n_cmp++;
        if (n_acc != 3 || n_done != 3) begin
            n_bad++;
            $display("FAIL b2b_totals: got acc=%0d done=%0d want 3/3", n_acc, n_done);
        end
        check_idle("b2b_end");
    endtask

    task automatic test_random();
        for (int k = 0; k < 30; k++) begin
            int ch;
            ch = int'($urandom_range(0, 26));
            if (ch < NCH) run_write(ch, 8'($urandom));
            else run_reject(ch);
            repeat ($urandom_range(0, 2)) @(negedge prog_clk);
        end
    endtask

    task automatic test_reset_mid_pulse();
        int ch;
        ch = int'($urandom_range(0, NCH - 1));
        cmd_valid = 1'b1;
        cmd_chunk = 5'(ch);
        cmd_data  = 8'($urandom);
        @(negedge prog_clk);
        cmd_valid = 1'b0;
        @(negedge prog_clk);
        n_cmp++;
        if (wl !== mask(ch)) begin
            n_bad++;
            $display("FAIL midrst_pulse: got wl=%h want %h", wl, mask(ch));
        end
        prog_reset = 1'b1;
        model_count = '0;
        @(negedge prog_clk);
        check_idle("midrst_abort");
        prog_reset = 1'b0;
        @(negedge prog_clk);
        check_idle("midrst_after");
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 10; k++) run_write(k, 8'($urandom));
        n_cmp++;
        if (w_count !== 3'd2 || write_count !== 16'd10) begin
            n_bad++;
            $display("FAIL wrap: got %0d/%0d want 2/10", w_count, write_count);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_directed();
        test_last_chunk();
        test_reject();
        test_back_to_back();
        test_random();
        test_reset_mid_pulse();
        test_wrap();
        repeat (2) @(negedge prog_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
